// File: rtl/corner_pkg.sv
// Shared types and defaults for the corner frame collector.
// Pure declarations, no latency.
// No flow control here; consumers handle backpressure.
package corner_pkg;

    localparam int COORD_W         = 10;
    localparam int MAX_CORNERS_DEF = 16;
    localparam int MIN_SEP_DEF     = 4;

    // One stored detection: pixel coordinates of a corner
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } corner_t;

    // Read-side streaming state
    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // Unsigned distance between two coordinates, never wraps
    function automatic logic [COORD_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/corner_bank.sv
// One coordinate bank: DEPTH entries, synchronous write, asynchronous read.
// Write lands on the clock edge, read data follows raddr combinationally.
// No backpressure; the owner decides when writes are legal.
module corner_bank
    import corner_pkg::*;
#(
    parameter int DEPTH = MAX_CORNERS_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  corner_t       wdata_i,
    input  logic [AW-1:0] raddr_i,
    output corner_t       rdata_o
);

    corner_t mem_q [DEPTH];

    // Store the accepted corner at the write index
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/corner_frame_collector.sv
// Collects corner strobes per frame into ping-pong banks and streams the finished bank.
// Publish 2 cycles after VS low is sampled; first entry presented with frame_ready.
// rd_ready low holds the current entry; a frame ending while streaming is discarded.
module corner_frame_collector
    import corner_pkg::*;
#(
    parameter int MAX_CORNERS = MAX_CORNERS_DEF,
    parameter int MIN_SEP     = MIN_SEP_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         VGA_VS,
    input  logic                         corner_detected,
    input  logic [COORD_W-1:0]           addr_corner_x,
    input  logic [COORD_W-1:0]           addr_corner_y,
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [COORD_W-1:0]           rd_x,
    output logic [COORD_W-1:0]           rd_y,
    output logic                         rd_last,
    output logic                         frame_ready,
    output logic [$clog2(MAX_CORNERS):0] frame_count,
    output logic                         frame_overflow,
    output logic [7:0]                   frames_dropped
);

    localparam int IW = $clog2(MAX_CORNERS);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0]      FULL_C = CW'(MAX_CORNERS);
    localparam logic [COORD_W-1:0] SEP_C  = COORD_W'(MIN_SEP);

    // Frame-end detection
    logic vs_q, vs_prev_q, fall_q;

    // Write side
    logic               wr_bank_q;
    logic [CW-1:0]      wr_count_q, wr_count_d, wr_count_inc;
    logic               wr_ovf_q, wr_ovf_d, wr_ovf_inc;
    logic [COORD_W-1:0] last_x_q, last_x_d, last_y_q, last_y_d;
    logic               full, dup, accept;

    // Read side
    rd_state_e     rd_state_q;
    logic [IW-1:0] rd_idx_q;
    logic          rd_valid_q, rd_last_q, frame_ready_q, frame_ovf_q;
    logic [CW-1:0] frame_count_q;
    logic [7:0]    frames_dropped_q;
    logic          publish, discard;

    corner_t wr_entry, bank0_rdata, bank1_rdata, rd_entry;

    // Register VS, then register the falling edge so publish lands two edges after sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            vs_q      <= VGA_VS;
            vs_prev_q <= vs_q;
            fall_q    <= vs_prev_q & ~vs_q;
        end
    end

    // A frame end either publishes the write bank or throws it away
    assign publish = fall_q && (rd_state_q == RD_IDLE);
    assign discard = fall_q && (rd_state_q == RD_STREAM);

    // Duplicate suppression and capacity check; the strobe in the frame-end cycle still counts
    always_comb begin
        full         = (wr_count_q == FULL_C);
        dup          = (wr_count_q != '0) && (addr_corner_y == last_y_q) &&
                       (abs_diff(addr_corner_x, last_x_q) <= SEP_C);
        accept       = corner_detected && !full && !dup;
        wr_count_inc = wr_count_q + CW'(accept);
        wr_ovf_inc   = wr_ovf_q | (corner_detected & full);
        wr_count_d   = wr_count_inc;
        wr_ovf_d     = wr_ovf_inc;
        last_x_d     = accept ? addr_corner_x : last_x_q;
        last_y_d     = accept ? addr_corner_y : last_y_q;
        if (publish || discard) begin
            wr_count_d = '0;
            wr_ovf_d   = 1'b0;
            last_x_d   = '0;
            last_y_d   = '0;
        end
    end

    // Write-side bookkeeping and bank swap on publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            wr_count_q <= '0;
            wr_ovf_q   <= 1'b0;
            last_x_q   <= '0;
            last_y_q   <= '0;
        end else begin
            wr_count_q <= wr_count_d;
            wr_ovf_q   <= wr_ovf_d;
            last_x_q   <= last_x_d;
            last_y_q   <= last_y_d;
            if (publish) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    assign wr_entry = '{x: addr_corner_x, y: addr_corner_y};

    corner_bank #(.DEPTH(MAX_CORNERS), .AW(IW)) u_bank0 (
        .clk     (clk),
        .we_i    (accept & ~wr_bank_q),
        .waddr_i (wr_count_q[IW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_idx_q),
        .rdata_o (bank0_rdata)
    );

    corner_bank #(.DEPTH(MAX_CORNERS), .AW(IW)) u_bank1 (
        .clk     (clk),
        .we_i    (accept & wr_bank_q),
        .waddr_i (wr_count_q[IW-1:0]),
        .wdata_i (wr_entry),
        .raddr_i (rd_idx_q),
        .rdata_o (bank1_rdata)
    );

    // The read bank is always the one not being written
    assign rd_entry = wr_bank_q ? bank0_rdata : bank1_rdata;

    // Read-side FSM: publish frame info, then stream entries under valid/ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q       <= RD_IDLE;
            rd_idx_q         <= '0;
            rd_valid_q       <= 1'b0;
            rd_last_q        <= 1'b0;
            frame_ready_q    <= 1'b0;
            frame_count_q    <= '0;
            frame_ovf_q      <= 1'b0;
            frames_dropped_q <= '0;
        end else begin
            frame_ready_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (fall_q) begin
                        frame_ready_q <= 1'b1;
                        frame_count_q <= wr_count_inc;
                        frame_ovf_q   <= wr_ovf_inc;
                        rd_idx_q      <= '0;
                        if (wr_count_inc != '0) begin
                            rd_state_q <= RD_STREAM;
                            rd_valid_q <= 1'b1;
                            rd_last_q  <= (wr_count_inc == CW'(1));
                        end
                    end
                end
                RD_STREAM: begin
                    if (fall_q && (frames_dropped_q != 8'hFF)) begin
                        frames_dropped_q <= frames_dropped_q + 8'd1;
                    end
                    if (rd_ready) begin
                        if (rd_last_q) begin
                            rd_state_q <= RD_IDLE;
                            rd_valid_q <= 1'b0;
                            rd_last_q  <= 1'b0;
                        end else begin
                            rd_idx_q  <= rd_idx_q + IW'(1);
                            rd_last_q <= (({1'b0, rd_idx_q} + CW'(2)) == frame_count_q);
                        end
                    end
                end
                default: begin
                    rd_state_q <= RD_IDLE;
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid       = rd_valid_q;
    assign rd_last        = rd_last_q;
    assign rd_x           = rd_valid_q ? rd_entry.x : '0;
    assign rd_y           = rd_valid_q ? rd_entry.y : '0;
    assign frame_ready    = frame_ready_q;
    assign frame_count    = frame_count_q;
    assign frame_overflow = frame_ovf_q;
    assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_corner_frame_collector.sv
// Randomised and directed bench with a list-level reference model and scoreboard.
// Stimulus pushes expected frames/entries; a negedge monitor pops and compares.
// rd_ready is forced or randomised to exercise stalls.
module tb_corner_frame_collector;

    localparam int MAXC = 16;
    localparam int SEP  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       VGA_VS = 1'b1;
    logic       corner_detected = 1'b0;
    logic [9:0] ax = '0;
    logic [9:0] ay = '0;
    logic       rd_ready = 1'b0;
    logic       rd_valid, rd_last, frame_ready, frame_overflow;
    logic [9:0] rd_x, rd_y;
    logic [4:0] frame_count;
    logic [7:0] frames_dropped;

    corner_frame_collector #(.MAX_CORNERS(MAXC), .MIN_SEP(SEP)) dut (
        .clk             (clk),
        .reset           (reset),
        .VGA_VS          (VGA_VS),
        .corner_detected (corner_detected),
        .addr_corner_x   (ax),
        .addr_corner_y   (ay),
        .rd_ready        (rd_ready),
        .rd_valid        (rd_valid),
        .rd_x            (rd_x),
        .rd_y            (rd_y),
        .rd_last         (rd_last),
        .frame_ready     (frame_ready),
        .frame_count     (frame_count),
        .frame_overflow  (frame_overflow),
        .frames_dropped  (frames_dropped)
    );

    initial forever #5 clk = ~clk;

    typedef struct { int x; int y; bit last; } ent_t;
    typedef struct { int cnt; int ovf; int dropped; } frm_t;

    ent_t exp_rd_q[$];
    frm_t exp_fr_q[$];
    ent_t cur_list[$];
    bit   cur_ovf = 0;
    int   exp_dropped = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   rdy_mode = 0;
    bit   rdy_force = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the frame keeps a list; a corner joins unless full or a same-row near duplicate of the last kept one
    task automatic model_add(input int x, input int y);
        ent_t ne;
        int   d;
        if (cur_list.size() >= MAXC) begin
            cur_ovf = 1;
        end else begin
            if (cur_list.size() > 0) d = (x > cur_list[$].x) ? x - cur_list[$].x : cur_list[$].x - x;
            else d = 0;
            if (cur_list.size() == 0 || y != cur_list[$].y || d > SEP) begin
                ne.x = x; ne.y = y; ne.last = 0;
                cur_list.push_back(ne);
            end
        end
    endtask

    // Reference: a frame ending while the consumer still owes entries is lost
    task automatic model_publish(output bit pub, output int cnt);
        frm_t f;
        ent_t e;
        if (exp_rd_q.size() > 0) begin
            pub = 0; cnt = 0;
            if (exp_dropped < 255) exp_dropped++;
        end else begin
            pub = 1; cnt = cur_list.size();
            f.cnt = cnt; f.ovf = int'(cur_ovf); f.dropped = exp_dropped;
            exp_fr_q.push_back(f);
            for (int i = 0; i < cnt; i++) begin
                e = cur_list[i];
                e.last = (i == cnt - 1);
                exp_rd_q.push_back(e);
            end
        end
        cur_list.delete();
        cur_ovf = 0;
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge
    task automatic strobe(input int x, input int y, input int gap);
        corner_detected = 1'b1; ax = 10'(x); ay = 10'(y);
        model_add(x, y);
        @(posedge clk); #1;
        corner_detected = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic end_frame(input bit coinc, input int cx, input int cy,
                             input bit aft, input int fx, input int fy);
        bit pub;
        int cnt;
        VGA_VS = 1'b0; corner_detected = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("frame_ready_early", int'(frame_ready), 0);
        if (coinc) begin
            corner_detected = 1'b1; ax = 10'(cx); ay = 10'(cy);
            model_add(cx, cy);
        end
        model_publish(pub, cnt);
        @(posedge clk); #1;
        chk("frame_ready_latency", int'(frame_ready), int'(pub));
        if (pub) begin
            chk("rd_valid_latency", int'(rd_valid), int'(cnt > 0));
            if (cnt > 0) begin
                chk("first_x", int'(rd_x), exp_rd_q[0].x);
                chk("first_y", int'(rd_y), exp_rd_q[0].y);
            end
        end
        corner_detected = 1'b0;
        if (aft) begin
            corner_detected = 1'b1; ax = 10'(fx); ay = 10'(fy);
            model_add(fx, fy);
        end
        @(posedge clk); #1;
        corner_detected = 1'b0; VGA_VS = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        rdy_force = 1'b1;
        while ((exp_rd_q.size() > 0 || exp_fr_q.size() > 0 || rd_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_entries_left", exp_rd_q.size(), 0);
        chk("drain_rd_valid", int'(rd_valid), 0);
    endtask

    // Ready driver, offset from the edge so the monitor sees a settled value
    initial forever begin
        @(posedge clk); #2;
        rd_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Scoreboard monitor
    initial begin
        ent_t e;
        frm_t f;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (frame_ready) begin
                    chk("frame_pending", int'(exp_fr_q.size() > 0), 1);
                    if (exp_fr_q.size() > 0) begin
                        f = exp_fr_q.pop_front();
                        chk("frame_count", int'(frame_count), f.cnt);
                        chk("frame_overflow", int'(frame_overflow), f.ovf);
                        chk("frames_dropped", int'(frames_dropped), f.dropped);
                    end
                end
                if (rd_valid) begin
                    chk("entry_pending", int'(exp_rd_q.size() > 0), 1);
                    if (exp_rd_q.size() > 0) begin
                        e = exp_rd_q[0];
                        chk("rd_x", int'(rd_x), e.x);
                        chk("rd_y", int'(rd_y), e.y);
                        chk("rd_last", int'(rd_last), int'(e.last));
                        if (rd_ready) void'(exp_rd_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bit c, a;
        int n;
        // Reset state
        #12;
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_last", int'(rd_last), 0);
        chk("rst_frame_ready", int'(frame_ready), 0);
        chk("rst_frame_count", int'(frame_count), 0);
        chk("rst_frame_overflow", int'(frame_overflow), 0);
        chk("rst_frames_dropped", int'(frames_dropped), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Basic three-corner frame, consumer always ready
        rdy_force = 1'b1;
        strobe(10, 5, 1); strobe(100, 5, 0); strobe(50, 9, 2);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(200);

        // Same-row dedup: distance 3 and 4 dropped, 5 kept, new row kept
        strobe(20, 7, 0); strobe(23, 7, 0); strobe(24, 7, 0); strobe(30, 7, 0);
        strobe(35, 7, 0); strobe(39, 7, 0); strobe(39, 8, 1);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(200);

        // Overflow: 20 distinct corners into a 16-entry bank
        for (int i = 0; i < 20; i++) strobe(i * 30 + 3, 2, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(300);

        // Empty frame
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(50);

        // Strobe in the detect cycle joins the ending frame; one edge later starts the next
        strobe(1, 1, 0);
        end_frame(1, 200, 3, 1, 300, 4);
        wait_drain(100);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(100);

        // Frame lost while the consumer stalls
        rdy_force = 1'b0;
        strobe(5, 5, 0); strobe(60, 6, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        strobe(7, 7, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("drop_count", int'(frames_dropped), exp_dropped);
        chk("drop_hold_valid", int'(rd_valid), 1);
        chk("drop_hold_x", int'(rd_x), exp_rd_q[0].x);
        chk("drop_hold_y", int'(rd_y), exp_rd_q[0].y);
        wait_drain(100);
        strobe(8, 8, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(100);

        // Reset mid-stream
        rdy_force = 1'b0;
        strobe(1, 2, 0); strobe(3, 4, 0); strobe(100, 4, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        chk("pre_reset_valid", int'(rd_valid), 1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("reset_rd_valid", int'(rd_valid), 0);
        chk("reset_frame_count", int'(frame_count), 0);
        chk("reset_frames_dropped", int'(frames_dropped), 0);
        chk("reset_frame_ready", int'(frame_ready), 0);
        exp_rd_q.delete(); exp_fr_q.delete(); cur_list.delete();
        cur_ovf = 0; exp_dropped = 0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rdy_force = 1'b1;
        strobe(9, 9, 0); strobe(12, 9, 0); strobe(14, 9, 0);
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(100);

        // Randomised frames with random consumer stalls
        rdy_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(0, 22);
            for (int i = 0; i < n; i++) begin
                strobe(($urandom_range(0, 7) == 0) ? $urandom_range(990, 1023) : $urandom_range(0, 40),
                       $urandom_range(0, 3), $urandom_range(0, 2));
            end
            wait_drain(2000);
            c = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 3) == 0);
            end_frame(c, $urandom_range(0, 40), $urandom_range(0, 3),
                      a, $urandom_range(0, 40), $urandom_range(0, 3));
        end
        wait_drain(2000);
        rdy_mode = 1'b0;
        rdy_force = 1'b1;
        end_frame(0, 0, 0, 0, 0, 0);
        wait_drain(200);
        chk("frames_left", exp_fr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
